// File: rtl/pc_sequencer.sv
// PC source sequencer: boot fetch, sequential fetch, branch redirect, stall hold
// and interrupt entry (drain, save PC, jump to vector 0).
module pc_sequencer #(
  parameter int unsigned BOOT_WAIT    = 2,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       stall,
  input  logic       branch_taken,
  input  logic       interrupt,
  output logic [1:0] selection,
  output logic       pc_enable,
  output logic       flush,
  output logic       save_pc,
  output logic       int_ack,
  output logic       irq_busy
);

  typedef enum logic [2:0] {
    BOOT,
    RUN,
    DRAIN,
    SAVE,
    VECTOR
  } state_t;

  localparam logic [2:0] BOOT_LAST  = 3'(BOOT_WAIT);
  localparam logic [2:0] DRAIN_LAST = 3'(DRAIN_CYCLES - 1);

  state_t     state, state_nxt;
  logic [2:0] cnt, cnt_nxt;
  logic       int_pending;
  logic       pending_now;

  // A pulse in the current RUN cycle counts as pending so DRAIN starts next cycle.
  assign pending_now = int_pending | interrupt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= BOOT;
      cnt         <= '0;
      int_pending <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      int_pending <= interrupt | (int_pending & ~int_ack);
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    selection = 2'b00;
    pc_enable = 1'b0;
    flush     = 1'b0;
    save_pc   = 1'b0;
    int_ack   = 1'b0;
    irq_busy  = 1'b0;

    case (state)
      BOOT: begin
        if (cnt == BOOT_LAST) begin
          selection = 2'b01;
          pc_enable = 1'b1;
          cnt_nxt   = '0;
          state_nxt = RUN;
        end else begin
          cnt_nxt = cnt + 3'd1;
        end
      end

      RUN: begin
        if (branch_taken) begin
          selection = 2'b11;
          pc_enable = 1'b1;
          flush     = 1'b1;
        end else if (!pending_now && !stall) begin
          pc_enable = 1'b1;
        end
        // A same-cycle branch still redirects; entry begins on the following cycle.
        if (pending_now) begin
          cnt_nxt   = '0;
          state_nxt = DRAIN;
        end
      end

      DRAIN: begin
        irq_busy = 1'b1;
        if (branch_taken) begin
          selection = 2'b11;
          pc_enable = 1'b1;
          flush     = 1'b1;
          cnt_nxt   = '0;
        end else if (!stall) begin
          if (cnt == DRAIN_LAST) begin
            state_nxt = SAVE;
          end else begin
            cnt_nxt = cnt + 3'd1;
          end
        end
      end

      SAVE: begin
        save_pc   = 1'b1;
        irq_busy  = 1'b1;
        state_nxt = VECTOR;
      end

      VECTOR: begin
        selection = 2'b10;
        pc_enable = 1'b1;
        flush     = 1'b1;
        int_ack   = 1'b1;
        irq_busy  = 1'b1;
        state_nxt = RUN;
      end

      default: begin
        state_nxt = BOOT;
        cnt_nxt   = '0;
      end
    endcase

    if (!rst) begin
      selection = 2'b00;
      pc_enable = 1'b0;
      flush     = 1'b0;
      save_pc   = 1'b0;
      int_ack   = 1'b0;
      irq_busy  = 1'b0;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed testbench for pc_sequencer: per-scenario stimulus tables with
// hand-computed output vectors {selection, pc_enable, flush, save_pc, int_ack, irq_busy}.
module tb_pc_sequencer;

  logic       clk;
  logic       rst;
  logic       stall;
  logic       branch_taken;
  logic       interrupt;
  logic [1:0] selection;
  logic       pc_enable;
  logic       flush;
  logic       save_pc;
  logic       int_ack;
  logic       irq_busy;

  int checks;
  int errors;

  logic [6:0] outs;
  assign outs = {selection, pc_enable, flush, save_pc, int_ack, irq_busy};

  localparam logic [6:0] O_IDLE  = 7'b00_0_0_0_0_0;
  localparam logic [6:0] O_NEXT  = 7'b00_1_0_0_0_0;
  localparam logic [6:0] O_BOOT  = 7'b01_1_0_0_0_0;
  localparam logic [6:0] O_BR    = 7'b11_1_1_0_0_0;
  localparam logic [6:0] O_DRAIN = 7'b00_0_0_0_0_1;
  localparam logic [6:0] O_DRBR  = 7'b11_1_1_0_0_1;
  localparam logic [6:0] O_SAVE  = 7'b00_0_0_1_0_1;
  localparam logic [6:0] O_VEC   = 7'b10_1_1_0_1_1;

  pc_sequencer #(
    .BOOT_WAIT   (2),
    .DRAIN_CYCLES(3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .branch_taken(branch_taken),
    .interrupt   (interrupt),
    .selection   (selection),
    .pc_enable   (pc_enable),
    .flush       (flush),
    .save_pc     (save_pc),
    .int_ack     (int_ack),
    .irq_busy    (irq_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // stim entries are {stall, branch_taken, interrupt}
  task automatic test_reset;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (outs !== O_IDLE) begin
        errors++;
        $display("FAIL reset cyc%0d outs=%b exp=%b", i, outs, O_IDLE);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_boot;
    logic [2:0] stim [5];
    logic [6:0] expv [5];
    stim = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
    expv = '{O_IDLE, O_IDLE, O_BOOT, O_NEXT, O_NEXT};
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      {stall, branch_taken, interrupt} = stim[i];
      @(negedge clk);
      checks++;
      if (outs !== expv[i]) begin
        errors++;
        $display("FAIL boot cyc%0d outs=%b exp=%b", i, outs, expv[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch_stall;
    logic [2:0] stim [4];
    logic [6:0] expv [4];
    stim = '{3'b110, 3'b100, 3'b100, 3'b000};
    expv = '{O_BR, O_IDLE, O_IDLE, O_NEXT};
    for (int i = 0; i < 4; i++) begin
      {stall, branch_taken, interrupt} = stim[i];
      @(negedge clk);
      checks++;
      if (outs !== expv[i]) begin
        errors++;
        $display("FAIL branch_stall cyc%0d outs=%b exp=%b", i, outs, expv[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_interrupt;
    logic [2:0] stim [8];
    logic [6:0] expv [8];
    stim = '{3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
    expv = '{O_IDLE, O_DRAIN, O_DRAIN, O_DRAIN, O_SAVE, O_VEC, O_NEXT, O_NEXT};
    for (int i = 0; i < 8; i++) begin
      {stall, branch_taken, interrupt} = stim[i];
      @(negedge clk);
      checks++;
      if (outs !== expv[i]) begin
        errors++;
        $display("FAIL interrupt cyc%0d outs=%b exp=%b", i, outs, expv[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_drain_stall;
    logic [2:0] stim [9];
    logic [6:0] expv [9];
    stim = '{3'b001, 3'b000, 3'b100, 3'b100, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
    expv = '{O_IDLE, O_DRAIN, O_DRAIN, O_DRAIN, O_DRAIN, O_DRAIN, O_SAVE, O_VEC, O_NEXT};
    for (int i = 0; i < 9; i++) begin
      {stall, branch_taken, interrupt} = stim[i];
      @(negedge clk);
      checks++;
      if (outs !== expv[i]) begin
        errors++;
        $display("FAIL drain_stall cyc%0d outs=%b exp=%b", i, outs, expv[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_drain_branch;
    logic [2:0] stim [10];
    logic [6:0] expv [10];
    stim = '{3'b001, 3'b000, 3'b000, 3'b010, 3'b000,
             3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
    expv = '{O_IDLE, O_DRAIN, O_DRAIN, O_DRBR, O_DRAIN,
             O_DRAIN, O_DRAIN, O_SAVE, O_VEC, O_NEXT};
    for (int i = 0; i < 10; i++) begin
      {stall, branch_taken, interrupt} = stim[i];
      @(negedge clk);
      checks++;
      if (outs !== expv[i]) begin
        errors++;
        $display("FAIL drain_branch cyc%0d outs=%b exp=%b", i, outs, expv[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch_irq;
    logic [2:0] stim [7];
    logic [6:0] expv [7];
    stim = '{3'b011, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
    expv = '{O_BR, O_DRAIN, O_DRAIN, O_DRAIN, O_SAVE, O_VEC, O_NEXT};
    for (int i = 0; i < 7; i++) begin
      {stall, branch_taken, interrupt} = stim[i];
      @(negedge clk);
      checks++;
      if (outs !== expv[i]) begin
        errors++;
        $display("FAIL branch_irq cyc%0d outs=%b exp=%b", i, outs, expv[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back;
    logic [2:0] stim [16];
    logic [6:0] expv [16];
    stim = '{3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000,
             3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
    expv = '{O_IDLE, O_IDLE, O_BOOT, O_IDLE, O_DRAIN, O_DRAIN, O_DRAIN, O_SAVE,
             O_VEC, O_IDLE, O_DRAIN, O_DRAIN, O_DRAIN, O_SAVE, O_VEC, O_NEXT};
    {stall, branch_taken, interrupt} = 3'b000;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 16; i++) begin
      {stall, branch_taken, interrupt} = stim[i];
      @(negedge clk);
      checks++;
      if (outs !== expv[i]) begin
        errors++;
        $display("FAIL back_to_back cyc%0d outs=%b exp=%b", i, outs, expv[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_in_save;
    logic [2:0] stim [5];
    logic [6:0] expv [5];
    logic [2:0] stim2 [6];
    logic [6:0] expv2 [6];
    stim  = '{3'b001, 3'b000, 3'b000, 3'b000, 3'b000};
    expv  = '{O_IDLE, O_DRAIN, O_DRAIN, O_DRAIN, O_SAVE};
    stim2 = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
    expv2 = '{O_IDLE, O_IDLE, O_BOOT, O_NEXT, O_NEXT, O_NEXT};
    for (int i = 0; i < 5; i++) begin
      {stall, branch_taken, interrupt} = stim[i];
      @(negedge clk);
      checks++;
      if (outs !== expv[i]) begin
        errors++;
        $display("FAIL save_seq cyc%0d outs=%b exp=%b", i, outs, expv[i]);
      end
      if (i < 4) begin
        @(posedge clk); #1;
      end
    end
    // Mid-cycle, well away from any clock edge.
    #1 rst = 1'b0;
    #1;
    checks++;
    if (outs !== O_IDLE) begin
      errors++;
      $display("FAIL async_reset outs=%b exp=%b", outs, O_IDLE);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      {stall, branch_taken, interrupt} = stim2[i];
      @(negedge clk);
      checks++;
      if (outs !== expv2[i]) begin
        errors++;
        $display("FAIL reboot cyc%0d outs=%b exp=%b", i, outs, expv2[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rst          = 1'b0;
    stall        = 1'b0;
    branch_taken = 1'b0;
    interrupt    = 1'b0;
    test_reset();
    test_boot();
    test_branch_stall();
    test_interrupt();
    test_drain_stall();
    test_drain_branch();
    test_branch_irq();
    test_back_to_back();
    test_reset_in_save();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
